bcd_scan_counter: RTL and testbench

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

---
 rtl/bcd_scan_counter.sv | 161 ++++++++++++++++
 tb/tb_bcd_scan_counter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with prescaled stepping, synchronous load,
// wrap/borrow pulse and a free-running multiplexed 7-segment digit scanner.
module bcd_scan_counter #(
    parameter int PRESCALE = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        carry
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ONE = PS_W'(1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCAN_DIV - 1);
    localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);

    logic [15:0]     count_q, count_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic [SC_W-1:0] scan_q,  scan_d;
    logic [1:0]      sel_q,   sel_d;
    logic            carry_q, carry_d;
    logic            tick_s;
    logic [16:0]     step_s;

    // Returns {wrap, next} for a BCD increment; wrap is set only for 9999->0000.
    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    c           = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return {c, r};
    endfunction

    // Returns {borrow, next} for a BCD decrement; borrow is set only for 0000->9999.
    function automatic logic [16:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                    b           = 1'b1;
                end else if (v[4*i +: 4] > 4'd9) begin
                    r[4*i +: 4] = 4'd9;
                    b           = 1'b0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return {b, r};
    endfunction

    // Non-BCD nibbles in a load value are forced to zero.
    function automatic logic [15:0] bcd_clean(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd0;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    assign tick_s = en && (presc_q == PS_MAX);

    // Count, prescaler and carry next-state; load outranks a coincident tick.
    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        carry_d = 1'b0;
        step_s  = up ? bcd_inc(count_q) : bcd_dec(count_q);
        if (load) begin
            count_d = bcd_clean(load_val);
            presc_d = '0;
        end else if (tick_s) begin
            count_d = step_s[15:0];
            presc_d = '0;
            carry_d = step_s[16];
        end else if (en) begin
            presc_d = presc_q + PS_ONE;
        end else begin
            presc_d = presc_q;
        end
    end

    // Free-running scan divider and digit pointer.
    always_comb begin
        scan_d = scan_q;
        sel_d  = sel_q;
        if (scan_q == SC_MAX) begin
            scan_d = '0;
            sel_d  = sel_q + 2'd1;
        end else begin
            scan_d = scan_q + SC_ONE;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 16'h0000;
            presc_q <= '0;
            scan_q  <= '0;
            sel_q   <= 2'd0;
            carry_q <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
            carry_q <= carry_d;
        end
    end

    // Display mux: combinational from count_q and sel_q so updates show without delay.
    always_comb begin
        digit = 4'h0;
        an    = 4'b1111;
        case (sel_q)
            2'd0:    begin digit = count_q[3:0];   an = 4'b1110; end
            2'd1:    begin digit = count_q[7:4];   an = 4'b1101; end
            2'd2:    begin digit = count_q[11:8];  an = 4'b1011; end
            2'd3:    begin digit = count_q[15:12]; an = 4'b0111; end
            default: begin digit = 4'h0;           an = 4'b1110; end
        endcase
    end

    assign count = count_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed self-checking bench for bcd_scan_counter with PRESCALE=4, SCAN_DIV=2.
module tb_bcd_scan_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [15:0] count;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        carry;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_scan_counter #(.PRESCALE(4), .SCAN_DIV(2)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .digit(digit), .an(an), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        edges(1);
        load     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_count"}, count, 16'h0000);
        check_eq({tag, "_an"}, 16'(an), 16'h000E);
        check_eq({tag, "_digit"}, 16'(digit), 16'h0000);
        check_eq({tag, "_carry"}, 16'(carry), 16'h0000);
    endtask

    logic [3:0]  an_tab [4];
    logic [15:0] exp_cnt;
    logic [3:0]  prev_an;
    logic        found;
    int          cnt;
    int          s;

    initial begin
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

        // Reset state and first scan advance
        @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        edges(1);
        check_eq("scan_first_hold", 16'(an), 16'h000E);
        edges(1);
        check_eq("scan_first_adv", 16'(an), 16'h000D);

        // Counting up 0000..0010, one step per 4 cycles, no carry
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_again");
        en = 1'b1;
        up = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            for (int c = 0; c < 4; c++) begin
                edges(1);
                check_eq("up_carry0", 16'(carry), 16'h0000);
            end
            exp_cnt = {8'h00, 4'(k / 10), 4'(k % 10)};
            check_eq("up_step", count, exp_cnt);
        end

        // Up wrap 9999 -> 0000 with one-cycle carry
        en = 1'b0;
        do_load(16'h9998);
        check_eq("load_9998", count, 16'h9998);
        en = 1'b1;
        edges(4);
        check_eq("up_9999", count, 16'h9999);
        check_eq("up_9999_carry", 16'(carry), 16'h0000);
        edges(4);
        check_eq("up_wrap", count, 16'h0000);
        check_eq("up_wrap_carry", 16'(carry), 16'h0001);
        edges(1);
        check_eq("up_wrap_carry_end", 16'(carry), 16'h0000);

        // Down wrap 0000 -> 9999 then 9998
        en = 1'b0;
        up = 1'b0;
        do_load(16'h0000);
        en = 1'b1;
        edges(4);
        check_eq("dn_wrap", count, 16'h9999);
        check_eq("dn_wrap_carry", 16'(carry), 16'h0001);
        edges(1);
        check_eq("dn_wrap_carry_end", 16'(carry), 16'h0000);
        edges(3);
        check_eq("dn_9998", count, 16'h9998);
        check_eq("dn_9998_carry", 16'(carry), 16'h0000);

        // Load sanitising and load coinciding with a tick
        up = 1'b1;
        do_load(16'h12F4);
        check_eq("load_clean", count, 16'h1204);
        edges(3);
        check_eq("pre_tick_hold", count, 16'h1204);
        do_load(16'h5555);
        check_eq("load_vs_tick", count, 16'h5555);
        check_eq("load_vs_tick_carry", 16'(carry), 16'h0000);
        edges(3);
        check_eq("load_clr_presc", count, 16'h5555);
        edges(1);
        check_eq("after_load_tick", count, 16'h5556);

        // Scan sequence on 4321
        en = 1'b0;
        do_load(16'h4321);
        found   = 1'b0;
        cnt     = 0;
        prev_an = an;
        while (!found && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
            prev_an = an;
        end
        check_eq("scan_align", 16'(found), 16'h0001);
        for (int i = 0; i < 16; i++) begin
            s = (i / 2) % 4;
            check_eq("scan_an", 16'(an), 16'(an_tab[s]));
            check_eq("scan_digit", 16'(digit), 16'(s + 1));
            @(negedge clk);
        end

        // Hold with en=0, then asynchronous reset discarding a pending tick
        do_load(16'h4321);
        en = 1'b1;
        edges(3);
        en = 1'b0;
        edges(20);
        check_eq("en0_hold", count, 16'h4321);
        en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        check_reset_outputs("async_rst_hold");
        rst = 1'b0;
        edges(3);
        check_eq("post_rst_no_tick", count, 16'h0000);
        edges(1);
        check_eq("post_rst_first_tick", count, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
